// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline queues: default widths, the NOP word
// and the wrap-around pointer helper.
package pipe_pkg;

   localparam int unsigned DEFAULT_XLEN      = 32;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   // Explicit compare so non-power-of-two depths wrap correctly.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/pipe_fifo_ctrl.sv
// Pointer, occupancy and full/empty control for a circular pipeline buffer.
// Storage lives in the instantiating stage; this block only says where to write/read.
module pipe_fifo_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          push,
   output logic          in_ready,
   output logic          out_valid,
   output logic [PW-1:0] rd_ptr,
   output logic [PW-1:0] wr_ptr,
   output logic [CW-1:0] count
);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop;

   // Ready depends on registered occupancy only: a full buffer refuses even when popping.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign rd_ptr = rd_ptr_q;
   assign wr_ptr = wr_ptr_q;
   assign count  = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
         if (pop)  rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID buffer: a DEPTH-entry FIFO of PC/instruction pairs between fetch and decode,
// flushed on redirect and presenting a NOP bubble to decode while empty.
module if_id_queue
   import pipe_pkg::*;
#(
   parameter int unsigned     XLEN      = DEFAULT_XLEN,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEFAULT_NOP_INSTR),
   localparam int unsigned    PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned    CW        = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            inValid,
   output logic            inReady,
   input  logic [XLEN-1:0] inPc,
   input  logic [XLEN-1:0] inInstr,
   output logic            outValid,
   input  logic            outReady,
   output logic [XLEN-1:0] outPc,
   output logic [XLEN-1:0] outInstr,
   output logic [CW-1:0]   count
);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic            push;

   pipe_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (inValid),
      .out_ready (outReady),
      .push      (push),
      .in_ready  (inReady),
      .out_valid (outValid),
      .rd_ptr    (rd_ptr),
      .wr_ptr    (wr_ptr),
      .count     (count)
   );

   // Entry data is never cleared; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= inPc;
         instr_mem[wr_ptr] <= inInstr;
      end
   end

   always_comb begin
      outPc    = '0;
      outInstr = NOP_INSTR;
      if (outValid) begin
         outPc    = pc_mem[rd_ptr];
         outInstr = instr_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and randomised checks of if_id_queue at DEPTH 2, 3 and 4.
module tb_if_id_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   localparam logic [67:0] EMPTY = {1'b1 ^ 1'b1, 1'b1, 2'd0, 32'd0, 32'h0000_0013};

   // DEPTH=2 instance
   logic        reset, flush, in_valid, out_ready, in_ready, out_valid;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [1:0]  count;
   logic [67:0] obs;
   assign obs = {out_valid, in_ready, count, out_pc, out_instr};

   if_id_queue #(.XLEN(32), .DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .reset(reset), .flush(flush), .inValid(in_valid), .inReady(in_ready),
      .inPc(in_pc), .inInstr(in_instr), .outValid(out_valid), .outReady(out_ready),
      .outPc(out_pc), .outInstr(out_instr), .count(count)
   );

   // DEPTH=3 and DEPTH=4 instances for the randomised sweep
   logic        f3, v3, r3, ir3, ov3, f4, v4, r4, ir4, ov4;
   logic [31:0] p3, i3, op3, oi3, p4, i4, op4, oi4;
   logic [1:0]  c3;
   logic [2:0]  c4;

   if_id_queue #(.XLEN(32), .DEPTH(3), .NOP_INSTR(32'h0000_0013)) dut3 (
      .clk(clk), .reset(reset), .flush(f3), .inValid(v3), .inReady(ir3),
      .inPc(p3), .inInstr(i3), .outValid(ov3), .outReady(r3),
      .outPc(op3), .outInstr(oi3), .count(c3)
   );

   if_id_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut4 (
      .clk(clk), .reset(reset), .flush(f4), .inValid(v4), .inReady(ir4),
      .inPc(p4), .inInstr(i4), .outValid(ov4), .outReady(r4),
      .outPc(op4), .outInstr(oi4), .count(c4)
   );

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return pc ^ 32'hABCD_0000;
   endfunction

   // Expected DEPTH=2 observation with pc at the head and c entries held
   function automatic logic [67:0] head(input logic [31:0] pc, input int c);
      return {1'b1, (c != 2), 2'(c), pc, ins(pc)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins(pc);
      out_ready = r;
      flush     = f;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", obs, EMPTY);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", obs, EMPTY);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] pcs [3];
      pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pcs[i], 1'b1, 1'b0);
         step();
         checks++;
         if (obs !== head(pcs[i], 1)) begin
            failures++;
            $display("FAIL stream_%0d got=%h exp=%h", i, obs, head(pcs[i], 1));
         end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL stream_drain got=%h exp=%h", obs, EMPTY);
      end
   endtask

   task automatic test_stall_fill();
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h14, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h18, 1'b0, 1'b0);
      checks++;
      if (obs !== head(32'h10, 2)) begin
         failures++;
         $display("FAIL stall_full got=%h exp=%h", obs, head(32'h10, 2));
      end
      step();
      checks++;
      if (obs !== head(32'h10, 2)) begin
         failures++;
         $display("FAIL stall_refuse got=%h exp=%h", obs, head(32'h10, 2));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (obs !== head(32'h14, 1)) begin
         failures++;
         $display("FAIL stall_pop1 got=%h exp=%h", obs, head(32'h14, 1));
      end
      step();
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL stall_pop2 got=%h exp=%h", obs, EMPTY);
      end
   endtask

   task automatic test_full_mixed();
      logic [31:0] q[$];
      logic [67:0] exp;
      logic [9:0]  vpat, rpat;
      vpat = 10'b11_1101_1011;
      rpat = 10'b01_0110_1100;
      drive(1'b1, 32'h20, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      step();
      // full: push offered and pop together -> push refused
      drive(1'b1, 32'h28, 1'b1, 1'b0);
      step();
      checks++;
      if (obs !== head(32'h24, 1)) begin
         failures++;
         $display("FAIL full_push_pop got=%h exp=%h", obs, head(32'h24, 1));
      end
      q.push_back(32'h24);
      for (int i = 0; i < 10; i++) begin
         logic do_push, do_pop;
         logic [31:0] pc;
         pc = 32'h100 + 32'(4 * i);
         drive(vpat[i], pc, rpat[i], 1'b0);
         do_push = vpat[i] && (q.size() < 2);
         do_pop  = rpat[i] && (q.size() > 0);
         step();
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(pc);
         if (q.size() == 0) exp = EMPTY;
         else exp = head(q[0], q.size());
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL mixed_%0d got=%h exp=%h", i, obs, exp);
         end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      step();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h30, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h34, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h40, 1'b1, 1'b1);
      step();
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL flush_clear got=%h exp=%h", obs, EMPTY);
      end
      drive(1'b1, 32'h80, 1'b0, 1'b0);
      step();
      checks++;
      if (obs !== head(32'h80, 1)) begin
         failures++;
         $display("FAIL flush_refetch got=%h exp=%h", obs, head(32'h80, 1));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h50, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h54, 1'b0, 1'b0);
      step();
      checks++;
      if (obs !== head(32'h50, 2)) begin
         failures++;
         $display("FAIL reset_mid_fill got=%h exp=%h", obs, head(32'h50, 2));
      end
      drive(1'b1, 32'h58, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", obs, EMPTY);
      end
      step();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (obs !== EMPTY) begin
         failures++;
         $display("FAIL reset_after got=%h exp=%h", obs, EMPTY);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] q3[$], q4[$];
      logic [31:0] n3, n4;
      logic [67:0] e3, g3;
      logic [68:0] e4, g4;
      n3 = 32'h1000;
      n4 = 32'h2000;
      for (int cyc = 0; cyc < 300; cyc++) begin
         logic pu3, po3, pu4, po4;
         f3 = ($urandom_range(0, 31) == 0);
         f4 = ($urandom_range(0, 31) == 0);
         v3 = 1'($urandom_range(0, 1));
         r3 = 1'($urandom_range(0, 1));
         v4 = 1'($urandom_range(0, 1));
         r4 = 1'($urandom_range(0, 1));
         p3 = n3; i3 = ins(n3);
         p4 = n4; i4 = ins(n4);
         pu3 = !f3 && v3 && (q3.size() < 3);
         po3 = !f3 && r3 && (q3.size() > 0);
         pu4 = !f4 && v4 && (q4.size() < 4);
         po4 = !f4 && r4 && (q4.size() > 0);
         step();
         if (f3) q3.delete();
         if (po3) void'(q3.pop_front());
         if (pu3) begin q3.push_back(n3); n3 += 4; end
         if (f4) q4.delete();
         if (po4) void'(q4.pop_front());
         if (pu4) begin q4.push_back(n4); n4 += 4; end
         if (q3.size() == 0) e3 = EMPTY;
         else e3 = {1'b1, (q3.size() != 3), 2'(q3.size()), q3[0], ins(q3[0])};
         if (q4.size() == 0) e4 = {1'b0, 1'b1, 3'd0, 32'd0, 32'h13};
         else e4 = {1'b1, (q4.size() != 4), 3'(q4.size()), q4[0], ins(q4[0])};
         g3 = {ov3, ir3, c3, op3, oi3};
         g4 = {ov4, ir4, c4, op4, oi4};
         checks++;
         if (g3 !== e3) begin
            failures++;
            $display("FAIL sweep_d3_%0d got=%h exp=%h", cyc, g3, e3);
         end
         checks++;
         if (g4 !== e4) begin
            failures++;
            $display("FAIL sweep_d4_%0d got=%h exp=%h", cyc, g4, e4);
         end
      end
      f3 = 1'b0; v3 = 1'b0; r3 = 1'b0;
      f4 = 1'b0; v4 = 1'b0; r4 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      f3 = 1'b0; v3 = 1'b0; r3 = 1'b0; p3 = '0; i3 = '0;
      f4 = 1'b0; v4 = 1'b0; r4 = 1'b0; p4 = '0; i4 = '0;
      test_reset();
      test_streaming();
      test_stall_fill();
      test_full_mixed();
      test_flush();
      test_reset_mid();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline buffer between the fetch stage (PC loader plus ROM) and the decoder. It replaces the single-entry IF/ID register with a DEPTH-entry FIFO that uses valid/ready handshakes on both sides, so fetch can keep running while decode is stalled. It has a redirect flush for taken branches and jumps. While empty it drives a NOP bubble to decode.

## Interface
Parameters:
- XLEN, 32, width of PC and instruction
- DEPTH, 2, number of entries; legal range 2..8
- NOP_INSTR, 32'h0000_0013, instruction driven while empty (addi x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  redirect from the branch unit; drops every entry
- inValid  in  1  fetch presents a PC/instruction pair
- inReady  out  1  buffer can accept this cycle
- inPc  in  XLEN  PC of the fetched instruction
- inInstr  in  XLEN  instruction word from ROM
- outValid  out  1  head entry valid toward decode
- outReady  in  1  decode accepts; the hazard unit drives it low to stall
- outPc  out  XLEN  PC of the head entry, sent to decode and the branch unit
- outInstr  out  XLEN  head instruction; NOP_INSTR when empty
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Circular buffer with rdPtr and wrPtr, each 0..DEPTH-1. Each pointer wraps to 0 after DEPTH-1. Both pointers are explicit compares, so non-power-of-two DEPTH is legal.
- push = inValid & inReady & !flush.
- pop = outValid & outReady & !flush.
- inReady = (count != DEPTH). It is a function of registered state only, with no combinational path from outReady. While full, a push is refused even in a cycle that pops.
- outValid = (count != 0).
- outPc and outInstr are driven from the entry at rdPtr when outValid=1. When empty they are 0 and NOP_INSTR.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged; the write goes to wrPtr and the read advances rdPtr
- Flush has priority over everything. On the next edge count=0 and rdPtr=wrPtr=0. Any same-cycle push is discarded and no pop is counted. Entry data is not cleared.
- Reset, asynchronously: count=0, rdPtr=0, wrPtr=0. Outputs therefore settle immediately to outValid=0, inReady=1, outPc=0, outInstr=NOP_INSTR, count=0. Reset may assert at any cycle, including mid-push or mid-flush, and all state is lost.
- Storage contents need no reset.

## Timing
- Latency is 1 cycle. A pair pushed at edge t appears on outPc and outInstr with outValid=1 after edge t.
- Throughput is 1 per cycle while outReady=1 and the buffer is not full.
- Decode stall (outReady=0): the head entry holds steady. Fetch fills the buffer until count=DEPTH, then inReady=0.
- When outReady returns to 1 with the buffer full, inReady rises one cycle after the first pop.
- Flush at edge t: outValid=0 and inReady=1 after t. The first post-redirect fetch can be pushed in cycle t+1.
- Push while empty: there is no same-cycle bypass to the output.

## Structure
- Shared package `pipe_pkg`:
  - XLEN default
  - NOP_INSTR constant
  - `function next_ptr(ptr, depth)` for wrap-around
- One sub-module is natural: `pipe_fifo_ctrl`, holding the pointers, count and the full/empty logic. It is reusable for the ID/EX and EX/MEM queues.
- The storage array stays inline in `if_id_queue`.

## Test plan
- Reset mid-traffic: reset asserted asynchronously while count=2 -> outValid=0, count=0, outInstr=32'h13 and inReady=1 immediately, before any clock edge.
- Streaming: push PCs 0x00,0x04,0x08 on consecutive cycles with outReady=1 -> outPc shows 0x00,0x04,0x08 one cycle later each, and count stays ≤1.
- Stall fill: outReady=0, push 0x10,0x14,0x18 -> count reaches 2, inReady=0 on the third attempt, 0x18 is not stored. Then outReady=1 -> 0x10 and 0x14 come out in order, and inReady=1 after the first pop.
- Full with simultaneous events: count=2, push offered and pop in the same cycle -> push refused, count becomes 1, pointers wrap correctly over 10 cycles of mixed traffic (checked against a scoreboard).
- Flush priority: count=2, flush=1 with inValid=1 (PC 0x40) and outReady=1 -> count=0 next cycle and 0x40 is dropped. Then push 0x80 -> outPc=0x80 one cycle later.
- Parameter sweep: DEPTH=3 and DEPTH=4 with XLEN=32 and random valid/ready -> no loss or duplication, order preserved, count never exceeds DEPTH.
